// File: rtl/clint_timer.sv
// clint_timer: CLINT msip / mtime / mtimecmp registers on a 32-bit port.
// Define CLINT_PRESCALE_EN to advance mtime once every PRESCALE clocks.
module clint_timer #(
  parameter int unsigned PRESCALE = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  typedef struct packed {
    logic msip;
    logic cmp_lo;
    logic cmp_hi;
    logic mt_lo;
    logic mt_hi;
  } sel_t;

  sel_t        sel;
  logic        tick;
  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] shadow;
  logic [31:0] rd_mux;

  always_comb begin
    sel = '0;
    case (addr[4:2])
      3'd0:    sel.msip   = 1'b1;
      3'd2:    sel.cmp_lo = 1'b1;
      3'd3:    sel.cmp_hi = 1'b1;
      3'd4:    sel.mt_lo  = 1'b1;
      3'd5:    sel.mt_hi  = 1'b1;
      default: sel        = '0;
    endcase
  end

`ifdef CLINT_PRESCALE_EN
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic        unused_cfg;

  assign tick       = (pcnt == LAST);
  assign unused_cfg = ^addr[1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end
`else
  logic unused_cfg;

  assign tick       = 1'b1;
  assign unused_cfg = ^{addr[1:0], (PRESCALE != 0)};
`endif

  // A write to either mtime half wins over that cycle's tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mtime <= '0;
    end else if (wen && sel.mt_lo) begin
      mtime[31:0] <= wdata;
    end else if (wen && sel.mt_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (wen) begin
      if (sel.cmp_lo) mtimecmp[31:0]  <= wdata;
      if (sel.cmp_hi) mtimecmp[63:32] <= wdata;
      if (sel.msip)   msip            <= wdata[0];
    end
  end

  // Hi half reads the shadow latched by the preceding lo read.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel.msip:   rd_mux = {31'd0, msip};
      sel.cmp_lo: rd_mux = mtimecmp[31:0];
      sel.cmp_hi: rd_mux = mtimecmp[63:32];
      sel.mt_lo:  rd_mux = mtime[31:0];
      sel.mt_hi:  rd_mux = shadow;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      shadow <= '0;
    end else begin
      rvalid <= ren;
      if (ren) rdata <= rd_mux;
      if (ren && sel.mt_lo) shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_interrupt <= 1'b0;
    end else begin
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

  assign software_interrupt = msip;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed vectors, read results checked via scoreboard.
// Build with CLINT_PRESCALE_EN to run the prescale sequence instead.
module tb_clint_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        timer_interrupt;
  logic        software_interrupt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  adr_q[$];

  clint_timer #(.PRESCALE(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .addr               (addr),
    .wen                (wen),
    .ren                (ren),
    .wdata              (wdata),
    .rdata              (rdata),
    .rvalid             (rvalid),
    .timer_interrupt    (timer_interrupt),
    .software_interrupt (software_interrupt)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    logic [31:0] e;
    logic [4:0]  a;
    if (rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected rdata=%h", rdata);
      end else begin
        e = exp_q.pop_front();
        a = adr_q.pop_front();
        if (rdata !== e) begin
          failures++;
          $display("FAIL read_%02h got=%h want=%h", a, rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
  endtask

  task automatic rd(logic [4:0] a, logic [31:0] e);
    addr = a;
    ren  = 1'b1;
    exp_q.push_back(e);
    adr_q.push_back(a);
    step();
    ren  = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_tirq", {31'd0, timer_interrupt}, 32'd0);
    chk("rst_sirq", {31'd0, software_interrupt}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) step();
    chk_reset_state();
    reset = 1'b1;

`ifdef CLINT_PRESCALE_EN
    repeat (4) step();
    rd(5'h10, 32'd1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd(5'h10, 32'd0);
    step();
    step();
    rd(5'h10, 32'd0);
    rd(5'h10, 32'd1);
    rd(5'h14, 32'd0);
    chk("ps_tirq", {31'd0, timer_interrupt}, 32'd0);
    chk("ps_sirq", {31'd0, software_interrupt}, 32'd0);
`else
    repeat (10) step();
    rd(5'h10, 32'd10);
    chk("idle_tirq", {31'd0, timer_interrupt}, 32'd0);
    chk("idle_sirq", {31'd0, software_interrupt}, 32'd0);

    wr(5'h0C, 32'd0);
    wr(5'h08, 32'h20);
    wr(5'h10, 32'd0);
    repeat (32) step();
    chk("cmp_before", {31'd0, timer_interrupt}, 32'd0);
    step();
    chk("cmp_rise", {31'd0, timer_interrupt}, 32'd1);
    wr(5'h0C, 32'd1);
    chk("cmp_hold", {31'd0, timer_interrupt}, 32'd1);
    step();
    chk("cmp_drop", {31'd0, timer_interrupt}, 32'd0);

    addr  = 5'h08;
    wdata = 32'h55;
    wen   = 1'b1;
    ren   = 1'b1;
    exp_q.push_back(32'h20);
    adr_q.push_back(5'h08);
    step();
    wen   = 1'b0;
    ren   = 1'b0;
    rd(5'h08, 32'h55);
    rd(5'h0C, 32'd1);

    wr(5'h14, 32'd0);
    wr(5'h10, 32'hFFFF_FFFF);
    rd(5'h10, 32'hFFFF_FFFF);
    rd(5'h14, 32'd0);
    rd(5'h10, 32'd1);
    rd(5'h14, 32'd1);

    wr(5'h08, 32'hFFFF_FFFF);
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h10, 32'hFFFF_FFFF);
    chk("wrap_pre", {31'd0, timer_interrupt}, 32'd0);
    step();
    rd(5'h10, 32'd0);
    chk("wrap_tirq0", {31'd0, timer_interrupt}, 32'd0);
    rd(5'h14, 32'd0);
    chk("wrap_tirq1", {31'd0, timer_interrupt}, 32'd0);

    wr(5'h00, 32'd3);
    chk("msip_set", {31'd0, software_interrupt}, 32'd1);
    rd(5'h00, 32'd1);
    wr(5'h00, 32'd0);
    chk("msip_clr", {31'd0, software_interrupt}, 32'd0);
    wr(5'h00, 32'd2);
    chk("msip_bit1", {31'd0, software_interrupt}, 32'd0);

    wr(5'h18, 32'hDEAD_BEEF);
    rd(5'h18, 32'd0);
    rd(5'h04, 32'd0);
    rd(5'h1C, 32'd0);
    rd(5'h0B, 32'hFFFF_FFFF);

    reset = 1'b0;
    addr  = 5'h00;
    wdata = 32'd1;
    wen   = 1'b1;
    ren   = 1'b1;
    step();
    reset = 1'b1;
    wen   = 1'b0;
    ren   = 1'b0;
    chk_reset_state();
    rd(5'h10, 32'd0);
    rd(5'h0C, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
